// File: rtl/piso_tx_arbiter_if.sv
// Requester-side bus of the PISO transmit arbiter: request levels, flattened
// parallel words, and the grant/load/status signals returned by the arbiter.
interface piso_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        i_req;
  logic [N_REQ*DATA_W-1:0] i_data;
  logic [N_REQ-1:0]        o_gnt;
  logic                    o_load;
  logic [DATA_W-1:0]       o_load_data;
  logic [2:0]              o_owner;
  logic                    o_busy;
  logic                    o_done;
  logic [7:0]              o_frame_cnt;

  // Requester side: drives requests and words, observes grant and status.
  modport master (
    output i_req, i_data,
    input  o_gnt, o_load, o_load_data, o_owner, o_busy, o_done, o_frame_cnt
  );

  // Arbiter side.
  modport slave (
    input  i_req, i_data,
    output o_gnt, o_load, o_load_data, o_owner, o_busy, o_done, o_frame_cnt
  );
endinterface

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter that feeds one shared PISO shifter: grants one requester,
// issues a load strobe with its word, then waits out the shifter's busy window.
module piso_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 4,
  parameter int SHIFT_CYCLES = 5
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  piso_tx_arbiter_if.slave    bus,
  output logic                o_dbg_state
);

  localparam int CNT_W = (SHIFT_CYCLES < 2) ? 1 : $clog2(SHIFT_CYCLES);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Handshake: a requester holds i_req and its word stable until it sees its
  // o_gnt bit; the word is captured on the same edge that raises o_gnt, and a
  // request still high afterwards is treated as a fresh request.
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_ptr;
  logic [N_REQ-1:0]    r_gnt;
  logic                r_load;
  logic [DATA_W-1:0]   r_load_data;
  logic [2:0]          r_owner;
  logic                r_busy;
  logic                r_done;
  logic [7:0]          r_frame_cnt;

  logic                w_hit;
  logic [2:0]          w_win;
  logic [N_REQ-1:0]    w_gnt;
  logic [DATA_W-1:0]   w_word;

  // Search starts just after the last winner and wraps modulo N_REQ.
  always_comb begin
    int idx;
    w_hit  = 1'b0;
    w_win  = '0;
    w_gnt  = '0;
    w_word = '0;
    idx    = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!w_hit && bus.i_req[idx]) begin
        w_hit      = 1'b1;
        w_win      = 3'(idx);
        w_gnt[idx] = 1'b1;
        w_word     = bus.i_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= 3'(N_REQ - 1);
      r_gnt       <= '0;
      r_load      <= 1'b0;
      r_load_data <= '0;
      r_owner     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (w_hit) begin
            r_gnt       <= w_gnt;
            r_load      <= 1'b1;
            r_load_data <= w_word;
            r_owner     <= w_win;
            r_ptr       <= w_win;
            r_busy      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_cnt       <= CNT_W'(SHIFT_CYCLES - 1);
            r_state     <= WAIT;
          end else begin
            r_gnt  <= '0;
            r_load <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        WAIT: begin
          r_gnt  <= '0;
          r_load <= 1'b0;
          // Last WAIT cycle: the following cycle is IDLE and flags completion.
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_gnt       = r_gnt;
  assign bus.o_load      = r_load;
  assign bus.o_load_data = r_load_data;
  assign bus.o_owner     = r_owner;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_frame_cnt = r_frame_cnt;
  assign o_dbg_state     = (r_state == WAIT);

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter with a small behavioural shifter model
// attached to the load strobe.
module tb_piso_tx_arbiter;

  logic i_clk;
  logic i_rst_n;
  logic dbg_state;

  int errors = 0;
  int checks = 0;

  piso_tx_arbiter_if #(.N_REQ(4), .DATA_W(4)) bus ();

  piso_tx_arbiter #(.N_REQ(4), .DATA_W(4), .SHIFT_CYCLES(5)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural 4-bit PISO shifter, LSB first
  logic [3:0] sh_reg;
  logic [2:0] sh_cnt;
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_reg <= '0;
      sh_cnt <= '0;
    end else if (bus.o_load) begin
      sh_reg <= bus.o_load_data;
      sh_cnt <= 3'd4;
    end else if (sh_cnt != 0) begin
      sh_reg <= sh_reg >> 1;
      sh_cnt <= sh_cnt - 3'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Waits for the next o_load; returns negedges taken and whether o_done was
  // seen in the cycle just before it.
  task automatic wait_load(input int max, output int cyc, output bit done_prev);
    bit pd;
    pd = 1'b0;
    cyc = 0;
    done_prev = 1'b0;
    for (int n = 1; n <= max; n++) begin
      @(negedge i_clk);
      if (bus.o_load) begin
        cyc = n;
        done_prev = pd;
        break;
      end
      pd = bus.o_done;
    end
    check("load_seen", 32'(cyc != 0), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"},   32'(bus.o_gnt),       32'd0);
    check({tag, "_load"},  32'(bus.o_load),      32'd0);
    check({tag, "_ldata"}, 32'(bus.o_load_data), 32'd0);
    check({tag, "_owner"}, 32'(bus.o_owner),     32'd0);
    check({tag, "_busy"},  32'(bus.o_busy),      32'd0);
    check({tag, "_done"},  32'(bus.o_done),      32'd0);
    check({tag, "_frame"}, 32'(bus.o_frame_cnt), 32'd0);
  endtask

  initial begin
    int cyc;
    bit dp;
    int loads;
    logic [3:0] exp_bits;
    logic [3:0] exp_gnt [5];
    logic [3:0] exp_dat [5];

    i_rst_n = 1'b0;
    bus.i_req = '0;
    bus.i_data = '0;

    // Reset state
    @(negedge i_clk);
    check_idle_outputs("rst");
    check("rst_state", 32'(dbg_state), 32'd0);
    i_rst_n = 1'b1;

    // Single request, word A: latency, status and serial bits
    bus.i_req = 4'b0001;
    bus.i_data = 16'h000A;
    wait_load(4, cyc, dp);
    check("t1_latency", 32'(cyc), 32'd1);
    check("t1_gnt",   32'(bus.o_gnt),       32'h1);
    check("t1_ldata", 32'(bus.o_load_data), 32'hA);
    check("t1_owner", 32'(bus.o_owner),     32'd0);
    check("t1_busy",  32'(bus.o_busy),      32'd1);
    check("t1_frame", 32'(bus.o_frame_cnt), 32'd1);
    bus.i_req = '0;
    exp_bits = 4'hA;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      check("t1_serial", 32'(sh_reg[0]), 32'(exp_bits[i]));
      check("t1_busy_w", 32'(bus.o_busy), 32'd1);
      check("t1_gnt_w",  32'(bus.o_gnt),  32'd0);
    end
    @(negedge i_clk);
    check("t1_done", 32'(bus.o_done), 32'd1);
    check("t1_busy_end", 32'(bus.o_busy), 32'd0);
    @(negedge i_clk);
    check("t1_done_pulse", 32'(bus.o_done), 32'd0);

    // All four requesting: round-robin order and 6-cycle spacing
    reset_dut();
    bus.i_req = 4'b1111;
    bus.i_data = 16'h4321;
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    for (int i = 0; i < 5; i++) begin
      wait_load(12, cyc, dp);
      if (i > 0) check("t2_spacing", 32'(cyc), 32'd6);
      check("t2_gnt",   32'(bus.o_gnt),       32'(exp_gnt[i]));
      check("t2_ldata", 32'(bus.o_load_data), 32'(exp_dat[i]));
    end
    bus.i_req = '0;

    // Pointer wrap: after req 2, 0101 grants 0 then 2
    bus.i_req = 4'b0100;
    wait_load(12, cyc, dp);
    check("t3_gnt2", 32'(bus.o_gnt), 32'b0100);
    check("t3_own2", 32'(bus.o_owner), 32'd2);
    bus.i_req = 4'b0101;
    wait_load(12, cyc, dp);
    check("t3_gnt0", 32'(bus.o_gnt), 32'b0001);
    check("t3_own0", 32'(bus.o_owner), 32'd0);
    wait_load(12, cyc, dp);
    check("t3_gnt2b", 32'(bus.o_gnt), 32'b0100);
    bus.i_req = '0;

    // Request raised and dropped within WAIT is ignored
    bus.i_req = 4'b0001;
    wait_load(12, cyc, dp);
    bus.i_req = '0;
    @(negedge i_clk);
    bus.i_req = 4'b1000;
    @(negedge i_clk);
    @(negedge i_clk);
    bus.i_req = '0;
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (bus.o_load) loads++;
    end
    check("t4_no_load", 32'(loads), 32'd0);

    // Asynchronous reset two cycles after a load
    bus.i_req = 4'b0001;
    bus.i_data = 16'h0007;
    wait_load(12, cyc, dp);
    bus.i_req = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_idle_outputs("t5");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus.i_req = 4'b0010;
    wait_load(4, cyc, dp);
    check("t5_latency", 32'(cyc), 32'd1);
    check("t5_gnt",   32'(bus.o_gnt),       32'b0010);
    check("t5_owner", 32'(bus.o_owner),     32'd1);
    check("t5_frame", 32'(bus.o_frame_cnt), 32'd1);
    bus.i_req = '0;

    // 256 back-to-back frames: counter wraps, done immediately precedes load
    reset_dut();
    bus.i_req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      wait_load(12, cyc, dp);
      if (i > 0) begin
        check("t6_spacing", 32'(cyc), 32'd6);
        check("t6_done_gap", 32'(dp), 32'd1);
      end
      check("t6_frame", 32'(bus.o_frame_cnt), 32'((i + 1) & 8'hFF));
    end
    bus.i_req = '0;
    check("t6_frame_wrap", 32'(bus.o_frame_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
